// File: rtl/contador_updown_mod.sv
// contador_updown_mod: parametrised up/down counter with a configurable modulus.
// It can wrap or saturate at the ends of its range. It also provides a
// synchronous clear, a parallel load that clamps to the range, a count enable,
// and registered carry/borrow wrap pulses.
module contador_updown_mod #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MAX_VAL  = 9,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             up,
  input  logic             down,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_min,
  output logic             carry,
  output logic             borrow
);

  localparam logic [WIDTH-1:0] LP_MAX = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] r_count;
  logic             r_carry;
  logic             r_borrow;

  logic             w_inc;
  logic             w_dec;
  logic [WIDTH-1:0] w_load_clamped;

  // Step requests: a step needs the enable and exactly one direction.
  always_comb begin
    w_inc          = en & up & ~down;
    w_dec          = en & down & ~up;
    w_load_clamped = (load_value > LP_MAX) ? LP_MAX : load_value;
  end

  // Count register with priority reset > clear > load > step > hold.
  // The wrap pulses are one-cycle flags. They are cleared on every edge that does not wrap.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count  <= '0;
      r_carry  <= 1'b0;
      r_borrow <= 1'b0;
    end else if (clear) begin
      r_count  <= '0;
      r_carry  <= 1'b0;
      r_borrow <= 1'b0;
    end else if (load) begin
      r_count  <= w_load_clamped;
      r_carry  <= 1'b0;
      r_borrow <= 1'b0;
    end else begin
      r_carry  <= 1'b0;
      r_borrow <= 1'b0;
      if (w_inc) begin
        if (r_count == LP_MAX) begin
          if (!SATURATE) begin
            r_count <= '0;
            r_carry <= 1'b1;
          end
        end else begin
          r_count <= r_count + 1'b1;
        end
      end else if (w_dec) begin
        if (r_count == '0) begin
          if (!SATURATE) begin
            r_count  <= LP_MAX;
            r_borrow <= 1'b1;
          end
        end else begin
          r_count <= r_count - 1'b1;
        end
      end
    end
  end

  // Range flags are decoded from the count register only.
  always_comb begin
    count  = r_count;
    at_max = (r_count == LP_MAX);
    at_min = (r_count == '0);
    carry  = r_carry;
    borrow = r_borrow;
  end

endmodule
